fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  PC generation and instruction prefetch stage, directly upstream of the combinational instruction memory.
//  Drives the word address and captures the returned instruction word with its PC.
//  Holds fetched words in a small FIFO (the fetch queue) that feeds decode over a valid/ready handshake.
//  Handles control-flow redirects from execute.
// PARAMETERS
//  ADDR_WIDTH  32           PC / instruction address width
//  DATA_WIDTH  32           instruction word width
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  FQ_DEPTH    2            fetch queue entries; power of two, >= 2
// PORTS
//  clk            in   1           single clock, all state on rising edge
//  reset          in   1           synchronous, active-high
//  instr_addr     out  ADDR_WIDTH  fetch address to instruction memory (= pc)
//  instr_in       in   DATA_WIDTH  instruction memory read data, combinational from instr_addr
//  redirect_valid in   1           taken branch/jump; the fetch stream restarts at redirect_pc
//  redirect_pc    in   ADDR_WIDTH  redirect target
//  dec_ready      in   1           decode accepts the head entry this cycle
//  dec_valid      out  1           head entry valid
//  dec_instr      out  DATA_WIDTH  head instruction
//  dec_pc         out  ADDR_WIDTH  PC of head instruction
//  dec_pc_plus4   out  ADDR_WIDTH  dec_pc + 4, modulo 2^ADDR_WIDTH
//  fetch_misalign out  1           present only with FETCH_MISALIGN_TRAP_EN
// BEHAVIOUR
//  Reset:
//   - pc <= RESET_PC; queue empty; count 0.
//   - dec_valid = 0; dec_instr, dec_pc and dec_pc_plus4 = 0; fetch_misalign = 0.
//   - Reset mid-operation discards all queue entries on that same edge.
//  Fetch and pop:
//   - instr_addr = pc continuously.
//   - pop = dec_valid & dec_ready.
//   - push = !redirect_valid & (count < FQ_DEPTH | pop).
//   - A full queue with a same-cycle pop still pushes.
//   - On push: enqueue {pc, instr_in}; pc <= pc + 4. The PC wraps from 2^ADDR_WIDTH-4 to 0.
//   - No push: pc holds.
//  Latency:
//   - A word fetched at edge N is visible on dec_* after edge N (registered queue). Head is never bypassed.
//   - Steady state with dec_ready held high: one instruction per cycle, no bubbles after the first.
//  Handshake:
//   - dec_valid = (count != 0).
//   - dec_* stable while dec_valid & !dec_ready.
//   - dec_valid never drops without a pop, except on redirect or reset.
//  Redirect (priority over push and pop):
//   - On the edge: queue flushed (count <= 0), pc <= redirect_pc.
//   - dec_valid = 0 in the following cycle.
//   - Any pop in the redirect cycle is still honoured by decode. The entry is discarded by the flush anyway.
//   - A fetch of the new target begins the cycle after the redirect.
//  Boundary conditions:
//   - Empty with dec_ready=1: no pop.
//   - Full with dec_ready=0: pc and queue hold.
//   - Back-to-back redirects: the last one wins.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//   - A redirect with redirect_pc[1:0] != 0 sets sticky fetch_misalign and pc <= redirect_pc.
//   - Pushes are inhibited until reset or a later aligned redirect, which clears the flag.
//  Undefined:
//   - Port absent; redirect_pc[1:0] forced to 0 when loaded into pc.
// STRUCTURE
//  Shared package riscv_pkg:
//   - RESET_PC default, INSTR_BYTES (4), NOP encoding 32'h0000_0013.
//  Sub-module fetch_queue:
//   - Parameterised FIFO with push/pop/flush, count, registered head.
//   - Pointers wrap modulo FQ_DEPTH.
//  Top: pc register, push/redirect control.
// TESTING
//  1. Reset -> instr_addr=0, dec_valid=0. Memory word i = 32'hA000_0000+i, dec_ready=1 -> dec_pc 0,4,8,... every cycle, dec_instr matching.
//  2. dec_ready=0 for 5 cycles -> queue fills (2 entries), pc holds at 8, dec_* stable. dec_ready=1 -> pc 0,4,8 in order, no loss/duplication.
//  3. redirect_valid=1, redirect_pc=32'h100 with a full queue -> next cycle dec_valid=0, instr_addr=0x100. Next dec_pc=0x100.
//  4. pc=32'hFFFF_FFFC fetch -> next instr_addr=0. dec_pc_plus4 for 0xFFFF_FFFC = 0.
//  5. Reset asserted while queue full and dec_ready=0 -> next cycle dec_valid=0, instr_addr=RESET_PC.
//  6. (FETCH_MISALIGN_TRAP_EN) redirect to 0x102 -> fetch_misalign=1, no dec_valid. Redirect to 0x200 -> flag clears, fetch resumes at 0x200.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the instruction fetch front end: reset vector, instruction size, NOP encoding.
package riscv_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instruction} pairs with synchronous flush; head is read from registered storage.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [ADDR_WIDTH-1:0]   push_pc,
  input  logic [DATA_WIDTH-1:0]   push_instr,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    head_valid,
  output logic [ADDR_WIDTH-1:0]   head_pc,
  output logic [DATA_WIDTH-1:0]   head_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // NOTE: storage is not reset; head outputs are masked by head_valid, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
  assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// PC generation and prefetch stage feeding decode through fetch_queue.
// Optional build macro FETCH_MISALIGN_TRAP_EN adds a sticky fetch_misalign output for unaligned redirects.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FQ_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  dec_ready,
  output logic                  dec_valid,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [ADDR_WIDTH-1:0] dec_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misalign
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  push;
  logic                  push_inhibit;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset)               misalign_q <= 1'b0;
    else if (redirect_valid) misalign_q <= |redirect_pc[1:0];
  end

  assign fetch_misalign  = misalign_q;
  assign push_inhibit    = misalign_q;
  assign redirect_target = redirect_pc;
`else
  assign push_inhibit    = 1'b0;
  assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
`endif

  assign instr_addr = pc;
  assign pop        = dec_valid & dec_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push       = !redirect_valid && !push_inhibit && ((count < CW'(FQ_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_target;
    else if (push)           pc <= pc + ADDR_WIDTH'(INSTR_BYTES);
  end

  fetch_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FQ_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (pc),
    .push_instr (instr_in),
    .pop        (pop),
    .count      (count),
    .head_valid (dec_valid),
    .head_pc    (dec_pc),
    .head_instr (dec_instr)
  );

  assign dec_pc_plus4 = dec_valid ? dec_pc + ADDR_WIDTH'(INSTR_BYTES) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      model_q[$];
  logic [31:0] model_pc;
  logic        model_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  assign instr_in = mem_word(instr_addr);

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .instr_addr     (instr_addr),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus4   (dec_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic chk);
    logic        v;
    logic        popped;
    logic        pushed;
    logic [31:0] hpc;
    reset = r; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
    #4;
    v   = (model_q.size() != 0);
    hpc = v ? model_q[0].pc : 32'h0;
    if (chk) begin
      check("instr_addr", instr_addr, model_pc);
      check("dec_valid", {31'b0, dec_valid}, {31'b0, v});
      check("dec_pc", dec_pc, hpc);
      check("dec_instr", dec_instr, v ? model_q[0].instr : 32'h0);
      check("dec_pc_plus4", dec_pc_plus4, v ? hpc + 32'd4 : 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, model_mis});
`endif
    end
    if (r) begin
      model_q.delete();
      model_pc  = RESET_PC;
      model_mis = 1'b0;
    end else if (rv) begin
      model_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      model_pc  = rpc;
      model_mis = (rpc[1:0] != 2'b00);
`else
      model_pc  = {rpc[31:2], 2'b00};
`endif
    end else begin
      popped = v && rdy;
      pushed = !model_mis && (model_q.size() < DEPTH || popped);
      if (popped) void'(model_q.pop_front());
      if (pushed) begin
        model_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_pc  = 32'h0;
    model_mis = 1'b0;

    // Reset state, then streaming with decode always ready.
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 1);
    repeat (8) cycle(0, 0, 0, 1, 1);

    // Stall from reset: queue fills, pc holds, then drain in order.
    cycle(1, 0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 1, 1);

    // Redirect while the queue is full.
    repeat (4) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 32'h0000_0100, 0, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);

    // Pop honoured in the redirect cycle; back-to-back redirects, last wins.
    cycle(0, 1, 32'h0000_0300, 1, 1);
    cycle(0, 1, 32'h0000_0400, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);

    // PC wrap from the top of the address space.
    cycle(0, 1, 32'hFFFF_FFF8, 1, 1);
    repeat (5) cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 32'hFFFF_FFFC, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);

    // Reset while full and stalled.
    repeat (4) cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);

    // Unaligned then aligned redirect.
    cycle(0, 1, 32'h0000_0102, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 32'h0000_0200, 1, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 99) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 32'h0000_0FFF));
      rdy = ($urandom_range(0, 99) < 65);
      cycle(r, rv, rpc, rdy, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
